udp_tx_fifo_sched: RTL and testbench
====================================

# udp_tx_fifo_sched

Read-side scheduler for the UDP transmit data FIFO. It monitors the FIFO read water level and decides when to release a packet: either a full payload is buffered, or a partial payload has waited past a timeout. It then handshakes a start/length request with the UDP transmit engine and drains exactly that many words from the FIFO as the engine pulls them. It sits between the FIFO read port (`c_OUTPUT_REG = 0`, one-cycle read latency) and the UDP TX engine, entirely in the read-clock domain.

## Interface
- `DATA_WIDTH`, 32: FIFO read word width. Must be a multiple of 8.
- `LEVEL_WIDTH`, 11: width of the FIFO read water level, equal to read depth width + 1.
- `PKT_WORDS`, 256: full-packet payload size in words. Range 1 to 2^(LEVEL_WIDTH-1).
- `TIMEOUT_CYCLES`, 4096: number of cycles a non-empty partial payload may wait before it is flushed. Must be ≥ 1.
- `IFG_CYCLES`, 12: idle gap after each packet before the next decision.
- `clk`, in, 1: read-side clock. All logic is on this clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `enable`, in, 1: when 0, no new packet is started.
- `fifo_rd_level`, in, LEVEL_WIDTH: FIFO read water level.
- `fifo_empty`, in, 1: FIFO read empty.
- `fifo_rd_data`, in, DATA_WIDTH: FIFO read data, valid one cycle after `fifo_rd_en`.
- `fifo_rd_en`, out, 1: FIFO read enable.
- `udp_tx_start`, out, 1: packet request, held until accepted.
- `udp_tx_len`, out, 16: payload length in bytes, equal to words × DATA_WIDTH/8. Stable while `udp_tx_start` is high.
- `udp_tx_ready`, in, 1: engine accepts the request in any cycle where `udp_tx_start` and `udp_tx_ready` are both 1.
- `udp_data_req`, in, 1: engine pulls one word.
- `udp_tx_data`, out, DATA_WIDTH: payload word (`fifo_rd_data` passed through).
- `udp_tx_valid`, out, 1: `udp_tx_data` is valid this cycle.
- `busy`, out, 1: state is not IDLE.
- `underrun`, out, 1: sticky error flag, cleared only by reset.
- `pkt_cnt`, out, 16: number of packets completed, wraps modulo 2^16.

## Operation
- **States:** IDLE, START, SEND, DRAIN, GAP.
- **IDLE:**
  - `wait_cnt` increments while `fifo_rd_level` is nonzero and below `PKT_WORDS`. It clears when the level is 0 or on leaving IDLE, and saturates at `TIMEOUT_CYCLES`.
  - If `enable` = 1 and `fifo_rd_level` ≥ `PKT_WORDS`: latch `burst` = `PKT_WORDS`, go to START.
  - Otherwise, if `enable` = 1, `wait_cnt` = `TIMEOUT_CYCLES` and the level is nonzero: latch `burst` = `fifo_rd_level`, go to START.
  - The full-packet condition has priority over the timeout.
- **START:** `udp_tx_start` = 1 and `udp_tx_len` = `burst` × DATA_WIDTH/8, truncated to 16 bits. On the accepting cycle, load `remaining` = `burst` and go to SEND.
- **SEND:**
  - `fifo_rd_en` = `udp_data_req` & (`remaining` ≠ 0) & ~`fifo_empty`. This is combinational.
  - Each cycle with `fifo_rd_en` = 1, `remaining` decrements by 1.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN:** one cycle, covering the last word's read latency. Then increment `pkt_cnt` and go to GAP.
- **GAP:** count `IFG_CYCLES` cycles, then go to IDLE. If `IFG_CYCLES` = 0, go straight to IDLE.
- **Valid output:** `udp_tx_valid` is a register equal to `fifo_rd_en` from the previous cycle. `udp_tx_data` = `fifo_rd_data`.
- **Underrun:** if `udp_data_req` = 1, `remaining` ≠ 0 and `fifo_empty` = 1 in SEND, set `underrun` and suppress the read. The packet continues when data arrives.
- **`enable` dropped mid-packet:** the current packet completes normally. Only the IDLE decision is gated.
- **Internal widths:** `burst`/`remaining` are LEVEL_WIDTH bits; `wait_cnt` is clog2(`TIMEOUT_CYCLES`+1) bits.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters 0. Reset asserts asynchronously; release is synchronous to `clk`.
- **Level to request:** the level crossing `PKT_WORDS` in cycle N gives `udp_tx_start` = 1 in cycle N+1.
- **Timeout path:** `udp_tx_start` rises `TIMEOUT_CYCLES`+1 cycles after the level first becomes nonzero, provided it stays below `PKT_WORDS`.
- **Request to data:** `udp_tx_ready` accepted in cycle A; the earliest `fifo_rd_en` is cycle A+1; its data is valid in cycle A+2.
- **Read-to-valid latency:** exactly 1 cycle.
- **Packet-to-packet spacing:** the last `fifo_rd_en` in cycle L gives DRAIN at L+1, `pkt_cnt` updated at L+2, GAP for L+2 through L+1+`IFG_CYCLES`, and IDLE at L+2+`IFG_CYCLES`. The earliest next `udp_tx_start` is the cycle after that.
- **Back-to-back reads:** `udp_data_req` held high gives one word per cycle with no bubbles.

## Test plan
- **Full packet:** `PKT_WORDS`=4 with 4 words 0x11..0x44 written → `udp_tx_start` with `udp_tx_len`=16. With `udp_data_req` held high after acceptance, `udp_tx_valid` is high for exactly 4 cycles carrying 0x11,0x22,0x33,0x44, and `pkt_cnt`=1.
- **Timeout flush:** `TIMEOUT_CYCLES`=8 with 3 words written → start at level-nonzero cycle + 9 with `udp_tx_len`=12, exactly 3 words read, and the FIFO ends empty.
- **Backpressure:** `udp_tx_ready` low for 5 cycles → `udp_tx_start` and `udp_tx_len` stay stable, no `fifo_rd_en`. `udp_data_req` toggling 1,0,1,0 → `fifo_rd_en` mirrors it and `udp_tx_valid` lags by 1 cycle.
- **Underrun:** force `fifo_empty`=1 during SEND while `udp_data_req`=1 → `fifo_rd_en`=0, `underrun`=1 and it stays set. Then release `fifo_empty` → the packet completes.
- **Enable and mid-packet reset:** `enable`=0 with level ≥ `PKT_WORDS` → no start for 100 cycles. Separately, assert `rst_n`=0 mid-SEND → `fifo_rd_en`, `udp_tx_valid` and `busy` go to 0 immediately (asynchronously) and `pkt_cnt`=0.
- **Back-to-back packets:** 8 words buffered with `PKT_WORDS`=4 and `IFG_CYCLES`=2 → two packets. The second `udp_tx_start` rises exactly 5 cycles after the first packet's last `fifo_rd_en`, and `pkt_cnt` ends at 2.

Source files
------------

// File: rtl/udp_tx_fifo_sched.sv
// udp_tx_fifo_sched: read-side scheduler for the UDP transmit data FIFO.
// Watches the FIFO read level, releases either a full payload or a
// timed-out partial payload, and handshakes a start/length request with
// the UDP TX engine. It then drains exactly that many words as the engine
// pulls them.
//
// Handshakes:
//   request: udp_tx_start is held high, with udp_tx_len stable, until a cycle
//            where udp_tx_ready is also high. That cycle is the transfer.
//   data:    each cycle with udp_data_req high pulls one word. fifo_rd_en
//            follows the request combinationally, and udp_tx_valid marks the
//            word one cycle later (FIFO read latency of 1).
module udp_tx_fifo_sched #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEVEL_WIDTH    = 11,
    parameter int PKT_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IFG_CYCLES     = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic                   udp_tx_start,
    output logic [15:0]            udp_tx_len,
    input  logic                   udp_tx_ready,
    input  logic                   udp_data_req,
    output logic [DATA_WIDTH-1:0]  udp_tx_data,
    output logic                   udp_tx_valid,
    output logic                   busy,
    output logic                   underrun,
    output logic [15:0]            pkt_cnt,
    output logic [2:0]             dbg_state_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int BYTES  = DATA_WIDTH / 8;

    localparam logic [LEVEL_WIDTH-1:0] PKT_LVL  = LEVEL_WIDTH'(PKT_WORDS);
    localparam logic [WAIT_W-1:0]      WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic [LEVEL_WIDTH-1:0] burst_q;
    logic [LEVEL_WIDTH-1:0] remaining_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic                   start_q;
    logic [15:0]            len_q;
    logic                   valid_q;
    logic                   underrun_q;
    logic [15:0]            pkt_cnt_q;

    logic                   level_nz_d;
    logic                   full_hit_d;
    logic                   timeout_hit_d;
    logic [LEVEL_WIDTH-1:0] burst_d;
    logic [15:0]            len_d;
    logic                   send_req_d;
    logic                   rd_en_d;
    logic                   underrun_hit_d;

    // Release decision, burst size and the SEND-state read/underrun strobes.
    always_comb begin
        level_nz_d     = (fifo_rd_level != '0);
        full_hit_d     = (fifo_rd_level >= PKT_LVL);
        timeout_hit_d  = (wait_cnt_q == WAIT_MAX) && level_nz_d;
        // A full payload always wins over a timed-out partial one.
        burst_d        = full_hit_d ? PKT_LVL : fifo_rd_level;
        len_d          = 16'(burst_d) * 16'(BYTES);
        send_req_d     = (state_q == S_SEND) && udp_data_req && (remaining_q != '0);
        rd_en_d        = send_req_d && !fifo_empty;
        underrun_hit_d = send_req_d && fifo_empty;
    end

    // Packet FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            burst_q     <= '0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            start_q     <= 1'b0;
            len_q       <= '0;
            valid_q     <= 1'b0;
            underrun_q  <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            valid_q <= rd_en_d;
            if (underrun_hit_d) begin
                underrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable && (full_hit_d || timeout_hit_d)) begin
                        burst_q    <= burst_d;
                        len_q      <= len_d;
                        start_q    <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_START;
                    end else if (!level_nz_d) begin
                        wait_cnt_q <= '0;
                    end else if (!full_hit_d && (wait_cnt_q != WAIT_MAX)) begin
                        // Only a partial payload ages; a full one just waits for enable.
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_START: begin
                    if (udp_tx_ready) begin
                        start_q     <= 1'b0;
                        remaining_q <= burst_q;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (rd_en_d) begin
                        remaining_q <= remaining_q - LEVEL_WIDTH'(1);
                        if (remaining_q == LEVEL_WIDTH'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last word's data is on the bus this cycle.
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    gap_cnt_q <= '0;
                    state_q   <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en   = rd_en_d;
    assign udp_tx_start = start_q;
    assign udp_tx_len   = len_q;
    assign udp_tx_data  = fifo_rd_data;
    assign udp_tx_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign underrun     = underrun_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
// Bench for udp_tx_fifo_sched: a queue-based FIFO model on the read side,
// a stream scoreboard on udp_tx_data, table-driven packet scenarios,
// hand-written corner sequences and a randomized packet phase.
module tb_udp_tx_fifo_sched;

    localparam int DW  = 32;
    localparam int LW  = 11;
    localparam int PKT = 4;
    localparam int TO  = 8;
    localparam int IFG = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          enable       = 1'b0;
    logic [LW-1:0] fifo_rd_level;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          udp_tx_start;
    logic [15:0]   udp_tx_len;
    logic          udp_tx_ready = 1'b0;
    logic          udp_data_req = 1'b0;
    logic [DW-1:0] udp_tx_data;
    logic          udp_tx_valid;
    logic          busy;
    logic          underrun;
    logic [15:0]   pkt_cnt;
    logic [2:0]    dbg_state;

    udp_tx_fifo_sched #(
        .DATA_WIDTH    (DW),
        .LEVEL_WIDTH   (LW),
        .PKT_WORDS     (PKT),
        .TIMEOUT_CYCLES(TO),
        .IFG_CYCLES    (IFG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_rd_level(fifo_rd_level),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .udp_tx_start (udp_tx_start),
        .udp_tx_len   (udp_tx_len),
        .udp_tx_ready (udp_tx_ready),
        .udp_data_req (udp_data_req),
        .udp_tx_data  (udp_tx_data),
        .udp_tx_valid (udp_tx_valid),
        .busy         (busy),
        .underrun     (underrun),
        .pkt_cnt      (pkt_cnt),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- FIFO model (read latency 1) ----------------
    logic          wr_en       = 1'b0;
    logic [DW-1:0] wr_data     = '0;
    logic          force_empty = 1'b0;
    logic [DW-1:0] mem_q[$];
    logic [LW-1:0] lvl_r;
    logic [DW-1:0] rd_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q.delete();
            lvl_r <= '0;
            rd_r  <= '0;
        end else begin
            if (fifo_rd_en && mem_q.size() > 0) rd_r <= mem_q.pop_front();
            if (wr_en) mem_q.push_back(wr_data);
            lvl_r <= LW'(mem_q.size());
        end
    end

    assign fifo_rd_level = lvl_r;
    assign fifo_empty    = (lvl_r == '0) || force_empty;
    assign fifo_rd_data  = rd_r;

    // ---------------- scoreboard / counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int exp_pkts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event within bound, expected event (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    int   rd_cnt         = 0;
    int   rd_cyc_q[$];
    int   start_rise_q[$];
    int   last_start_cyc = 0;
    int   lvl_rise_cyc   = 0;
    logic prev_start     = 1'b0;
    logic prev_lvl_nz    = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (udp_tx_start && !prev_start) begin
                start_rise_q.push_back(cyc);
                last_start_cyc = cyc;
            end
            if (fifo_rd_level != '0 && !prev_lvl_nz) lvl_rise_cyc = cyc;
            if (fifo_rd_en) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
            end
            if (udp_tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: got word 0x%0h, expected no word (cycle %0d)", udp_tx_data, cyc);
                end else begin
                    chk("sb_data", udp_tx_data, exp_q.pop_front());
                end
            end
        end
        prev_start  = udp_tx_start;
        prev_lvl_nz = (fifo_rd_level != '0);
    end

    // ---------------- driver tasks ----------------
    task automatic write_words(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = rnd ? DW'($urandom) : DW'(i + 1) * 32'h11;
            exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int w = 0; w < 300 && !seen; w++) begin
            @(negedge clk);
            #1;
            seen = udp_tx_start;
        end
        if (!seen) fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int w = 0; w < 300 && !seen; w++) begin
            @(negedge clk);
            #1;
            seen = !busy;
        end
        if (!seen) fail(name);
    endtask

    // Serve one packet: wait for the request, accept after rdy_dly cycles,
    // pull words with probability req_pct until the scheduler is idle again.
    task automatic run_pkt(input logic [15:0] exp_len, input int rdy_dly, input int req_pct);
        bit seen = 1'b0;
        rd_cnt = 0;
        wait_start("pkt_start_wait");
        chk("pkt_len", 32'(udp_tx_len), 32'(exp_len));
        repeat (rdy_dly) @(negedge clk);
        udp_tx_ready = 1'b1;
        @(negedge clk);
        udp_tx_ready = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            udp_data_req = ($urandom_range(0, 99) < req_pct);
            @(negedge clk);
            #1;
            seen = !busy;
        end
        udp_data_req = 1'b0;
        if (!seen) fail("pkt_drain_wait");
        exp_pkts++;
        chk("pkt_words", 32'(rd_cnt), 32'(exp_len) / 4);
        chk("pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));
    endtask

    // ---------------- table of packet scenarios ----------------
    typedef struct {
        int          n_words;
        logic [15:0] exp_len;
        int          exp_delay;  // level first nonzero -> udp_tx_start rise
    } vec_t;

    vec_t tbl[4];
    int   pat[7];

    initial begin
        int prev;
        int n;
        int k;
        int last_rd;
        int second_start;

        tbl[0] = '{n_words: 4, exp_len: 16'd16, exp_delay: 4};  // full: level hits 4 after 3 writes
        tbl[1] = '{n_words: 3, exp_len: 16'd12, exp_delay: 9};  // timeout flush
        tbl[2] = '{n_words: 1, exp_len: 16'd4,  exp_delay: 9};
        tbl[3] = '{n_words: 2, exp_len: 16'd8,  exp_delay: 9};
        pat    = '{1, 0, 1, 0, 1, 0, 1};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_start", 32'(udp_tx_start), 0);
        chk("rst_len", 32'(udp_tx_len), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(udp_tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // ---- table-driven full/timeout packets ----
        for (int t = 0; t < 4; t++) begin
            write_words(tbl[t].n_words, 1'b0);
            run_pkt(tbl[t].exp_len, 0, 100);
            chk("tbl_start_delay", 32'(last_start_cyc - lvl_rise_cyc), 32'(tbl[t].exp_delay));
            chk("tbl_fifo_level_end", 32'(fifo_rd_level), 0);
        end

        // ---- backpressure and toggled data requests ----
        write_words(4, 1'b1);
        wait_start("bp_start_wait");
        udp_data_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("bp_start_held", 32'(udp_tx_start), 1);
            chk("bp_len_stable", 32'(udp_tx_len), 16);
            chk("bp_no_rd_en", 32'(fifo_rd_en), 0);
            @(negedge clk);
            #1;
        end
        udp_tx_ready = 1'b1;
        #1;
        chk("bp_accept_no_rd_en", 32'(fifo_rd_en), 0);
        @(negedge clk);
        udp_tx_ready = 1'b0;
        rd_cnt = 0;
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            udp_data_req = pat[i][0];
            #1;
            chk("tog_rd_en", 32'(fifo_rd_en), 32'(pat[i]));
            chk("tog_valid", 32'(udp_tx_valid), 32'(prev));
            prev = pat[i];
            @(negedge clk);
        end
        udp_data_req = 1'b0;
        #1;
        chk("tog_last_valid", 32'(udp_tx_valid), 32'(prev));
        wait_idle("bp_idle_wait");
        exp_pkts++;
        chk("bp_words", 32'(rd_cnt), 4);
        chk("bp_pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));

        // ---- underrun ----
        write_words(4, 1'b1);
        wait_start("ur_start_wait");
        udp_tx_ready = 1'b1;
        @(negedge clk);
        udp_tx_ready = 1'b0;
        rd_cnt       = 0;
        udp_data_req = 1'b1;
        force_empty  = 1'b1;
        #1;
        chk("ur_rd_en_blocked", 32'(fifo_rd_en), 0);
        chk("ur_not_yet", 32'(underrun), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("ur_rd_en_blocked", 32'(fifo_rd_en), 0);
            chk("ur_sticky", 32'(underrun), 1);
        end
        force_empty = 1'b0;
        #1;
        chk("ur_resume_rd_en", 32'(fifo_rd_en), 1);
        wait_idle("ur_idle_wait");
        udp_data_req = 1'b0;
        exp_pkts++;
        chk("ur_words", 32'(rd_cnt), 4);
        chk("ur_still_set", 32'(underrun), 1);
        chk("ur_pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));

        // ---- back-to-back packets ----
        rd_cyc_q.delete();
        start_rise_q.delete();
        udp_tx_ready = 1'b1;
        udp_data_req = 1'b1;
        write_words(8, 1'b1);
        for (int w = 0; w < 300 && pkt_cnt != 16'(exp_pkts + 2); w++) @(negedge clk);
        wait_idle("b2b_idle_wait");
        udp_tx_ready = 1'b0;
        udp_data_req = 1'b0;
        exp_pkts += 2;
        chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));
        chk("b2b_reads", 32'(rd_cyc_q.size()), 8);
        chk("b2b_starts", 32'(start_rise_q.size()), 2);
        last_rd      = (rd_cyc_q.size() >= 4) ? rd_cyc_q[3] : -100;
        second_start = (start_rise_q.size() >= 2) ? start_rise_q[1] : 0;
        chk("b2b_spacing", 32'(second_start - last_rd), 32'(IFG + 3));

        // ---- enable low blocks a full payload ----
        enable = 1'b0;
        start_rise_q.delete();
        write_words(4, 1'b1);
        repeat (100) @(negedge clk);
        #1;
        chk("en_no_start", 32'(start_rise_q.size()), 0);
        chk("en_not_busy", 32'(busy), 0);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        #1;
        chk("en_start_next", 32'(udp_tx_start), 1);

        // ---- asynchronous reset mid-SEND ----
        udp_tx_ready = 1'b1;
        @(negedge clk);
        udp_tx_ready = 1'b0;
        udp_data_req = 1'b1;
        #1;
        chk("mid_pre_rd_en", 32'(fifo_rd_en), 1);
        chk("mid_pre_busy", 32'(busy), 1);
        @(negedge clk);
        #3;
        chk("mid_pre_valid", 32'(udp_tx_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("mid_rst_valid", 32'(udp_tx_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("mid_rst_underrun", 32'(underrun), 0);
        udp_data_req = 1'b0;
        exp_q.delete();
        exp_pkts = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- randomized packets against the payload model ----
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 11);
            write_words(n, 1'b1);
            k = n;
            while (k >= PKT) begin
                run_pkt(16'(PKT * 4), $urandom_range(0, 3), 60);
                k -= PKT;
            end
            if (k > 0) run_pkt(16'(k * 4), $urandom_range(0, 3), 60);
            chk("rnd_fifo_level_end", 32'(fifo_rd_level), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
